// File: rtl/denise_bitplanes_gen_if.sv
// denise_bitplanes_gen_if: chip-bus write port carrying per-plane fetch words
interface denise_bitplanes_gen_if #(parameter int FETCHW = 64);
   logic              wr_en;
   logic [2:0]        wr_plane;
   logic [FETCHW-1:0] wr_data;
   modport master (output wr_en, wr_plane, wr_data);
   modport slave  (input  wr_en, wr_plane, wr_data);
endinterface

// File: rtl/denise_bitplanes_gen.sv
// denise_bitplanes_gen: buffers fetch words, transfers them on clk7_en and serialises one bit per plane per pixel with per-playfield scroll delay
module denise_bitplanes_gen #(
   parameter int NPLANES = 8,
   parameter int FETCHW  = 64,
   parameter int SCROLLW = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clk7_en,
   denise_bitplanes_gen_if.slave bus,
   input  logic [1:0]           fmode,
   input  logic [SCROLLW-1:0]   scroll_odd,
   input  logic [SCROLLW-1:0]   scroll_even,
   input  logic                 pix_en,
   input  logic [NPLANES-1:0]   plane_mask,
   output logic [NPLANES-1:0]   bpldata,
   output logic                 underrun
);
   localparam int CW = $clog2(FETCHW + 1);
   localparam int HW = 2**SCROLLW - 1;
   logic [FETCHW-1:0]  hold_q [NPLANES];
   logic [FETCHW-1:0]  hold_d [NPLANES];
   logic [FETCHW-1:0]  shift_q [NPLANES];
   logic [FETCHW-1:0]  shift_d [NPLANES];
   logic [HW-1:0]      hist_q [NPLANES];
   logic [HW-1:0]      hist_d [NPLANES];
   logic [HW:0]        hx [NPLANES];
   logic [CW-1:0]      bitcnt_q, bitcnt_d, w;
   logic [SCROLLW-1:0] scr_odd_q, scr_odd_d, scr_even_q, scr_even_d;
   logic [NPLANES-1:0] bpldata_q, bpldata_d, msb;
   logic               load_pend_q, load_pend_d, arm_q, arm_d, underrun_q, underrun_d;
   logic               wr_hit, xfer;
   always_comb begin
      w           = CW'(FETCHW == 16 ? 16 : fmode == 2'b00 ? 16 : (fmode == 2'b11 && FETCHW == 64) ? 64 : 32);
      wr_hit      = clk7_en & bus.wr_en & (32'(bus.wr_plane) < NPLANES);
      xfer        = clk7_en & load_pend_q;
      load_pend_d = (wr_hit & (bus.wr_plane == 3'd0)) | (load_pend_q & ~xfer);
      underrun_d  = pix_en & ~xfer & arm_q & (bitcnt_q == '0);
      arm_d       = xfer | (arm_q & ~underrun_d);
      bitcnt_d    = xfer ? w : (pix_en && bitcnt_q != '0) ? bitcnt_q - CW'(1) : bitcnt_q;
      scr_odd_d   = xfer ? scroll_odd : scr_odd_q;
      scr_even_d  = xfer ? scroll_even : scr_even_q;
      // hx[d] is the bit emitted d pixels ago; hx[0] is the current MSB
      for (int i = 0; i < NPLANES; i++) begin
         msb[i]       = (bitcnt_q != '0) & shift_q[i][FETCHW-1];
         hx[i]        = {hist_q[i], msb[i]};
         hold_d[i]    = (wr_hit && bus.wr_plane == 3'(i)) ? bus.wr_data : hold_q[i];
         shift_d[i]   = xfer ? hold_q[i] : pix_en ? shift_q[i] << 1 : shift_q[i];
         hist_d[i]    = pix_en ? hx[i][HW-1:0] : hist_q[i];
         bpldata_d[i] = pix_en ? plane_mask[i] & hx[i][(i % 2 == 1) ? scr_even_q : scr_odd_q] : bpldata_q[i];
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_q      <= '{default: '0};
         shift_q     <= '{default: '0};
         hist_q      <= '{default: '0};
         bitcnt_q    <= '0;
         scr_odd_q   <= '0;
         scr_even_q  <= '0;
         bpldata_q   <= '0;
         load_pend_q <= 1'b0;
         arm_q       <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         hold_q      <= hold_d;
         shift_q     <= shift_d;
         hist_q      <= hist_d;
         bitcnt_q    <= bitcnt_d;
         scr_odd_q   <= scr_odd_d;
         scr_even_q  <= scr_even_d;
         bpldata_q   <= bpldata_d;
         load_pend_q <= load_pend_d;
         arm_q       <= arm_d;
         underrun_q  <= underrun_d;
      end
   end
   assign bpldata  = bpldata_q;
   assign underrun = underrun_q;
endmodule
